// File: rtl/div_sign_ctrl.sv
// Sign front-end/back-end wrapper around an unsigned SRT2 divider core (RV32IM DIV/DIVU/REM/REMU).
// Latency: special cases (x/0, MIN/-1) respond 1 cycle after accept; otherwise core latency + 3 cycles.
// Backpressure: one request in flight; in_ready only in IDLE; result/out_tag held while out_ready is low.
module div_sign_ctrl #(
  parameter int N    = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [N-1:0]    rs1,
  input  logic [N-1:0]    rs2,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    result,
  output logic [TAGW-1:0] out_tag,
  output logic            core_start,
  output logic [N-1:0]    core_numerator,
  output logic [N-1:0]    core_denominator,
  input  logic [N-1:0]    core_quotient,
  input  logic [N-1:0]    core_remainder,
  input  logic            core_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FIX,
    S_RESP
  } state_t;

  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0] MIN_NEG  = {1'b1, {(N-1){1'b0}}};

  state_t          state_q, state_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [N-1:0]    num_q, num_d;
  logic [N-1:0]    den_q, den_d;
  logic [N-1:0]    core_res_q, core_res_d;
  logic [N-1:0]    result_q, result_d;

  // Operand decode for the request presented this cycle.
  logic         op_signed;
  logic         op_rem;
  logic         rs1_neg;
  logic         rs2_neg;
  logic [N-1:0] rs1_mag;
  logic [N-1:0] rs2_mag;
  logic         fix_neg;

  // Signed operands are folded to magnitudes; -MIN wraps back to MIN, which the core treats as 2^(N-1).
  always_comb begin
    op_signed = ~op[0];
    op_rem    = op[1];
    rs1_neg   = op_signed & rs1[N-1];
    rs2_neg   = op_signed & rs2[N-1];
    rs1_mag   = rs1_neg ? (N'(0) - rs1) : rs1;
    rs2_mag   = rs2_neg ? (N'(0) - rs2) : rs2;
    fix_neg   = is_rem_q ? neg_rem_q : neg_quo_q;
  end

  // Next-state and datapath: special cases resolved at accept, everything else goes through the core.
  always_comb begin
    state_d    = state_q;
    is_rem_d   = is_rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    tag_d      = tag_q;
    num_d      = num_q;
    den_d      = den_q;
    core_res_d = core_res_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          is_rem_d  = op_rem;
          neg_quo_d = rs1_neg ^ rs2_neg;
          neg_rem_d = rs1_neg;
          tag_d     = in_tag;
          num_d     = rs1_mag;
          den_d     = rs2_mag;
          if (rs2 == '0) begin
            result_d = op_rem ? rs1 : ALL_ONES;
            state_d  = S_RESP;
          end else if (op_signed && (rs1 == MIN_NEG) && (rs2 == ALL_ONES)) begin
            result_d = op_rem ? '0 : MIN_NEG;
            state_d  = S_RESP;
          end else begin
            state_d  = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Only the half of the core result we will return is kept.
        if (core_done) begin
          core_res_d = is_rem_q ? core_remainder : core_quotient;
          state_d    = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_neg ? (N'(0) - core_res_q) : core_res_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      tag_q      <= '0;
      num_q      <= '0;
      den_q      <= '0;
      core_res_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      is_rem_q   <= is_rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      tag_q      <= tag_d;
      num_q      <= num_d;
      den_q      <= den_d;
      core_res_q <= core_res_d;
      result_q   <= result_d;
    end
  end

  // Handshake and launch strobes decode straight from the state register.
  always_comb begin
    in_ready         = (state_q == S_IDLE);
    out_valid        = (state_q == S_RESP);
    core_start       = (state_q == S_LAUNCH);
    result           = result_q;
    out_tag          = tag_q;
    core_numerator   = num_q;
    core_denominator = den_q;
  end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Directed bench for div_sign_ctrl with a behavioural unsigned divider core.
// Latency: core model raises done core_lat cycles after core_start.
// Backpressure: out_ready driven by the stimulus; held low in the backpressure sequence.
module tb_div_sign_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [4:0]  out_tag;
  logic        core_start;
  logic [31:0] core_numerator;
  logic [31:0] core_denominator;
  logic [31:0] core_quotient = '0;
  logic [31:0] core_remainder = '0;
  logic        core_done = 1'b0;

  int checks = 0;
  int errors = 0;

  div_sign_ctrl #(.N(32), .TAGW(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .op               (op),
    .rs1              (rs1),
    .rs2              (rs2),
    .in_tag           (in_tag),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .out_tag          (out_tag),
    .core_start       (core_start),
    .core_numerator   (core_numerator),
    .core_denominator (core_denominator),
    .core_quotient    (core_quotient),
    .core_remainder   (core_remainder),
    .core_done        (core_done)
  );

  always #5 clk = ~clk;

  // Behavioural SRT2 core: done drops after start, rises core_lat cycles later and stays high.
  int          core_lat = 3;
  int          core_cnt = 0;
  int          starts   = 0;
  logic [31:0] seen_num = '0;
  logic [31:0] seen_den = '0;
  always @(negedge clk) begin
    if (core_start) begin
      starts    = starts + 1;
      seen_num  = core_numerator;
      seen_den  = core_denominator;
      core_cnt  = core_lat;
      core_done = 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        core_done = 1'b1;
        if (seen_den == 0) begin
          core_quotient  = '1;
          core_remainder = seen_num;
        end else begin
          core_quotient  = seen_num / seen_den;
          core_remainder = seen_num % seen_den;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t);
    int w;
    op       = o;
    rs1      = a;
    rs2      = b;
    in_tag   = t;
    in_valid = 1'b1;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_at_request", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op       = 2'bxx;
    rs1      = 'x;
    rs2      = 'x;
    in_tag   = 'x;
  endtask

  // k = index of the first negedge after accept showing out_valid (1 = cycle T+1).
  task automatic wait_valid(output int k);
    k = 1;
    while (out_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    bit          special;
    logic [31:0] mag_num;
    logic [31:0] mag_den;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  initial begin
    int k;
    int s0;
    int ov_seen;

    // op: 0 DIV, 1 DIVU, 2 REM, 3 REMU
    vecs[0]  = '{2'd1, 32'd7,        32'd2,        5'd1,  32'd3,        1'b0, 32'd7,        32'd2};
    vecs[1]  = '{2'd3, 32'd7,        32'd2,        5'd2,  32'd1,        1'b0, 32'd7,        32'd2};
    vecs[2]  = '{2'd0, 32'hFFFFFFF9, 32'd2,        5'd3,  32'hFFFFFFFD, 1'b0, 32'd7,        32'd2};
    vecs[3]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFF, 1'b0, 32'd7,        32'd2};
    vecs[4]  = '{2'd0, 32'd7,        32'hFFFFFFFE, 5'd5,  32'hFFFFFFFD, 1'b0, 32'd7,        32'd2};
    vecs[5]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 5'd6,  32'd1,        1'b0, 32'd7,        32'd2};
    vecs[6]  = '{2'd0, 32'd5,        32'd0,        5'd7,  32'hFFFFFFFF, 1'b1, 32'd0,        32'd0};
    vecs[7]  = '{2'd2, 32'd5,        32'd0,        5'd8,  32'd5,        1'b1, 32'd0,        32'd0};
    vecs[8]  = '{2'd1, 32'd0,        32'd0,        5'd10, 32'hFFFFFFFF, 1'b1, 32'd0,        32'd0};
    vecs[9]  = '{2'd0, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1'b1, 32'd0,        32'd0};
    vecs[10] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1'b1, 32'd0,        32'd0};
    vecs[11] = '{2'd1, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1'b0, 32'h80000000, 32'hFFFFFFFF};
    vecs[12] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1'b0, 32'h80000000, 32'hFFFFFFFF};
    vecs[13] = '{2'd0, 32'hFFFFFFF8, 32'hFFFFFFFD, 5'd15, 32'd2,        1'b0, 32'd8,        32'd3};
    vecs[14] = '{2'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 5'd31, 32'hFFFFFFFE, 1'b0, 32'd8,        32'd3};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_result",     result,          32'd0);
    chk("rst_out_tag",    32'(out_tag),    32'd0);
    chk("rst_core_num",   core_numerator,  32'd0);
    chk("rst_core_den",   core_denominator, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors, consumer always ready.
    for (int i = 0; i < NV; i++) begin
      out_ready = 1'b1;
      s0 = starts;
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_valid(k);
      chk($sformatf("v%0d_latency", i), 32'(k), vecs[i].special ? 32'd1 : 32'(core_lat + 3));
      chk($sformatf("v%0d_result", i), result, vecs[i].exp);
      chk($sformatf("v%0d_tag", i), 32'(out_tag), 32'(vecs[i].tag));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready_after", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_out_valid_after", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_core_starts", i), 32'(starts - s0), vecs[i].special ? 32'd0 : 32'd1);
      if (!vecs[i].special) begin
        chk($sformatf("v%0d_core_num", i), seen_num, vecs[i].mag_num);
        chk($sformatf("v%0d_core_den", i), seen_den, vecs[i].mag_den);
      end
    end

    // Backpressure: hold the result for three cycles, then back-to-back tag 9.
    out_ready = 1'b0;
    send(2'd1, 32'd100, 32'd7, 5'd3);
    wait_valid(k);
    chk("bp_latency", 32'(k), 32'(core_lat + 3));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", c),  32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_result", c), result,         32'd14);
      chk($sformatf("bp_hold%0d_tag", c),    32'(out_tag),   32'd3);
      chk($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    chk("bp_out_valid_after", 32'(out_valid), 32'd0);
    send(2'd3, 32'd100, 32'd7, 5'd9);
    wait_valid(k);
    chk("b2b_result", result, 32'd2);
    chk("b2b_tag", 32'(out_tag), 32'd9);
    @(posedge clk);
    @(negedge clk);

    // Reset while waiting on a slow core; the late done must be ignored.
    core_lat = 20;
    send(2'd1, 32'd50, 32'd5, 5'd4);
    @(negedge clk);
    chk("wait_core_start_low", 32'(core_start), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready",   32'(in_ready),    32'd1);
    chk("arst_out_valid",  32'(out_valid),   32'd0);
    chk("arst_core_start", 32'(core_start),  32'd0);
    chk("arst_result",     result,           32'd0);
    chk("arst_out_tag",    32'(out_tag),     32'd0);
    chk("arst_core_num",   core_numerator,   32'd0);
    chk("arst_core_den",   core_denominator, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ov_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || in_ready !== 1'b1) ov_seen++;
    end
    chk("post_rst_no_result", 32'(ov_seen), 32'd0);

    core_lat = 3;
    s0 = starts;
    send(2'd1, 32'd9, 32'd4, 5'd6);
    wait_valid(k);
    chk("post_rst_latency", 32'(k), 32'd6);
    chk("post_rst_result", result, 32'd2);
    chk("post_rst_tag", 32'(out_tag), 32'd6);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_starts", 32'(starts - s0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_sign_ctrl.md
Name: div_sign_ctrl

Overview:
- Front-end/back-end controller for the unsigned SRT2 radix-2 divider core in the RV32IM M-extension datapath.
- Accepts DIV/DIVU/REM/REMU requests from the execute stage and resolves divide-by-zero and signed-overflow locally.
- Otherwise converts signed operands to magnitudes, launches the core, and sign-corrects its quotient/remainder.
- Returns one 32-bit result with its destination tag over a valid/ready handshake.

Parameters:
N, 32, operand/result width
TAGW, 5, destination-register tag width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  block idle, request accepted when in_valid&in_ready
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
rs1  input  N  dividend
rs2  input  N  divisor
in_tag  input  TAGW  destination tag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  N  quotient or remainder
out_tag  output  TAGW  tag of result
core_start  output  1  one-cycle launch pulse to SRT2 core
core_numerator  output  N  unsigned dividend magnitude (registered)
core_denominator  output  N  unsigned divisor magnitude (registered)
core_quotient  input  N  core quotient
core_remainder  input  N  core remainder
core_done  input  1  core result valid (level)

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0, core_start=0; result, out_tag, core_numerator, core_denominator = 0. Reset mid-operation aborts immediately; no result is produced for the aborted request.
- States: IDLE, LAUNCH, WAIT, FIX, RESP.
- IDLE: in_ready=1. On accept, latch op, in_tag, sign flags, and magnitudes.
  - signed = ~op[0]; is_rem = op[1].
  - |x| = x[N-1] & signed ? -x : x (mod 2^N, so |0x80000000| = 0x80000000).
  - rs2==0: result = is_rem ? rs1 : all-ones; go RESP.
  - signed & rs1==0x80000000 & rs2==all-ones: result = is_rem ? 0 : 0x80000000; go RESP.
  - Otherwise: go LAUNCH.
- LAUNCH: core_start=1 for exactly this cycle, with core_numerator/core_denominator stable. Go WAIT.
- WAIT: core_done is sampled only here; it is ignored in all other states. The core deasserts done from the cycle after core_start until its result is valid. On core_done=1, capture core_quotient/core_remainder and go FIX.
- FIX: neg_q = signed & (rs1 sign != rs2 sign); neg_r = signed & rs1 sign.
  - result = is_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo).
  - Go RESP.
- RESP: out_valid=1. result and out_tag are held stable while out_ready=0. On out_valid&out_ready, go IDLE; in_ready rises the next cycle. No new request is accepted in the handshake cycle.
- Latency from accept cycle T:
  - Special case: out_valid at T+1.
  - Normal: core_start at T+1; out_valid 2 cycles after core_done is first sampled high in WAIT.
- One request in flight. in_ready=0 in all states except IDLE.
- All arithmetic is mod 2^N. Remainder sign follows dividend; quotient truncates toward zero (RISC-V semantics).
- Inputs op, rs1, rs2, in_tag are don't-care outside the accept cycle.

Test Plan:
- DIVU 7/2 -> 3; REMU 7/2 -> 1. Exactly one core_start; core operands 7, 2.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1. Core sees magnitudes 7, 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIVU 0/0 -> 0xFFFFFFFF. out_valid at T+1; core_start never asserted.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0 with no core_start. DIVU 0x80000000/0xFFFFFFFF -> 0 via core.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after out_valid: result/out_tag stable, in_ready=0.
  - Raise out_ready: handshake completes, in_ready=1 the next cycle.
  - A back-to-back second request (tag 9) returns tag 9.
- Assert rst during WAIT:
  - All outputs return to reset values asynchronously.
  - A later core_done pulse produces no out_valid.
  - A new DIVU 9/4 after release -> 2.
